// File: rtl/gpio_serial_cfg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_serial_cfg
// Brief    : 3-wire serial frame receiver (csn/clk/dat from GPIO pads) that
//            presents checked addr/data words on a valid/ready handshake.
//            Optional trailing even parity: GPIO_SERIAL_CFG_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_serial_cfg #(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              ser_csn_i,
  input  logic              ser_clk_i,
  input  logic              ser_dat_i,
  output logic [ADDR_W-1:0] cfg_addr_o,
  output logic [DATA_W-1:0] cfg_data_o,
  output logic              cfg_valid_o,
  input  logic              cfg_ready_i,
  output logic              busy_o,
  output logic [1:0]        err_o,
  output logic              err_oeb_o
);

`ifdef GPIO_SERIAL_CFG_PARITY_EN
  localparam int c_PAR_W = 1;
`else
  localparam int c_PAR_W = 0;
`endif
  localparam int                 c_FRAME_LEN = ADDR_W + DATA_W + c_PAR_W;
  localparam int                 c_CNT_W     = $clog2(c_FRAME_LEN + 2);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(c_FRAME_LEN);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT   = c_CNT_W'(c_FRAME_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [SYNC_STAGES-1:0]   r_csn_sync;
  logic [SYNC_STAGES-1:0]   r_clk_sync;
  logic [SYNC_STAGES-1:0]   r_dat_sync;
  logic                     r_csn_d;
  logic                     r_clk_d;
  logic                     r_dat_d;
  logic                     r_csn_fall;
  logic                     r_csn_rise;
  logic                     r_clk_rise;

  logic [c_CNT_W-1:0]       r_cnt;
  logic [c_FRAME_LEN-1:0]   r_shreg;
  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_data;
  logic                     r_valid;
  logic [1:0]               r_err;

  // Sync chains reset to 0 so a pad already low at reset release never
  // looks like a csn falling edge; rising edges in IDLE are ignored.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_csn_sync <= '0;
      r_clk_sync <= '0;
      r_dat_sync <= '0;
      r_csn_d    <= 1'b0;
      r_clk_d    <= 1'b0;
      r_dat_d    <= 1'b0;
      r_csn_fall <= 1'b0;
      r_csn_rise <= 1'b0;
      r_clk_rise <= 1'b0;
    end else begin
      r_csn_sync <= {r_csn_sync[SYNC_STAGES-2:0], ser_csn_i};
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ser_clk_i};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ser_dat_i};
      r_csn_d    <= r_csn_sync[SYNC_STAGES-1];
      r_clk_d    <= r_clk_sync[SYNC_STAGES-1];
      r_dat_d    <= r_dat_sync[SYNC_STAGES-1];
      r_csn_fall <= r_csn_d & ~r_csn_sync[SYNC_STAGES-1];
      r_csn_rise <= ~r_csn_d & r_csn_sync[SYNC_STAGES-1];
      r_clk_rise <= ~r_clk_d & r_clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (r_csn_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_csn_rise) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // A good frame loaded in CHECK overrides the handshake clear, so a
  // coincident ready consumes the old word and the new one lands at once.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_cnt   <= '0;
      r_shreg <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 2'd0;
    end else begin
      if (r_valid && cfg_ready_i) r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_csn_fall) begin
            r_cnt   <= '0;
            r_shreg <= '0;
          end
        end
        ST_SHIFT: begin
          if (r_clk_rise) begin
            r_shreg <= {r_shreg[c_FRAME_LEN-2:0], r_dat_d};
            if (r_cnt != c_CNT_SAT) r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (r_cnt != c_CNT_FULL) begin
            r_err <= 2'd1;
          end
`ifdef GPIO_SERIAL_CFG_PARITY_EN
          else if (^r_shreg) begin
            r_err <= 2'd3;
          end
`endif
          else if (r_valid && !cfg_ready_i) begin
            r_err <= 2'd2;
          end else begin
            r_addr  <= r_shreg[c_PAR_W+DATA_W +: ADDR_W];
            r_data  <= r_shreg[c_PAR_W +: DATA_W];
            r_valid <= 1'b1;
            r_err   <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_addr_o  = r_addr;
  assign cfg_data_o  = r_data;
  assign cfg_valid_o = r_valid;
  assign busy_o      = (r_state != ST_IDLE);
  assign err_o       = r_err;
  assign err_oeb_o   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_gpio_serial_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_serial_cfg
// Brief    : Directed + randomized frames checked against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_serial_cfg;

  localparam int c_ADDR_W = 4;
  localparam int c_DATA_W = 24;
`ifdef GPIO_SERIAL_CFG_PARITY_EN
  localparam int c_FL = c_ADDR_W + c_DATA_W + 1;
`else
  localparam int c_FL = c_ADDR_W + c_DATA_W;
`endif
  localparam int c_HALF = 8;

  logic                r_clk   = 1'b0;
  logic                r_rst_n = 1'b0;
  logic                r_csn   = 1'b1;
  logic                r_sclk  = 1'b0;
  logic                r_sdat  = 1'b0;
  logic                r_ready = 1'b0;
  logic [c_ADDR_W-1:0] w_addr;
  logic [c_DATA_W-1:0] w_data;
  logic                w_valid;
  logic                w_busy;
  logic [1:0]          w_err;
  logic                w_oeb;

  gpio_serial_cfg #(
    .DATA_W      (c_DATA_W),
    .ADDR_W      (c_ADDR_W),
    .SYNC_STAGES (2)
  ) u_dut (
    .wb_clk_i    (r_clk),
    .wb_rst_n    (r_rst_n),
    .ser_csn_i   (r_csn),
    .ser_clk_i   (r_sclk),
    .ser_dat_i   (r_sdat),
    .cfg_addr_o  (w_addr),
    .cfg_data_o  (w_data),
    .cfg_valid_o (w_valid),
    .cfg_ready_i (r_ready),
    .busy_o      (w_busy),
    .err_o       (w_err),
    .err_oeb_o   (w_oeb)
  );

  always #5 r_clk = ~r_clk;

  int errors = 0;
  int checks = 0;

  // Frame-level model: the word held for the consumer and the last status.
  logic                m_valid = 1'b0;
  logic [c_ADDR_W-1:0] m_addr  = '0;
  logic [c_DATA_W-1:0] m_data  = '0;
  logic [1:0]          m_err   = 2'd0;

  task automatic tick(input int n);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(w_valid), 32'(m_valid));
    chk({tag, ".addr"},  32'(w_addr),  32'(m_addr));
    chk({tag, ".data"},  32'(w_data),  32'(m_data));
    chk({tag, ".err"},   32'(w_err),   32'(m_err));
    chk({tag, ".busy"},  32'(w_busy),  32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".valid"}, 32'(w_valid), 32'd0);
    chk({tag, ".addr"},  32'(w_addr),  32'd0);
    chk({tag, ".data"},  32'(w_data),  32'd0);
    chk({tag, ".err"},   32'(w_err),   32'd0);
    chk({tag, ".busy"},  32'(w_busy),  32'd0);
    chk({tag, ".oeb"},   32'(w_oeb),   32'd0);
  endtask

  function automatic logic [63:0] frame_bits(input logic [c_ADDR_W-1:0] a,
                                             input logic [c_DATA_W-1:0] d);
    logic [63:0] f;
`ifdef GPIO_SERIAL_CFG_PARITY_EN
    f = 64'({a, d, ^{a, d}});
`else
    f = 64'({a, d});
`endif
    return f;
  endfunction

  task automatic shift_bits(input logic [63:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      r_sdat = f[i];
      tick(c_HALF);
      r_sclk = 1'b1;
      tick(c_HALF);
      r_sclk = 1'b0;
    end
  endtask

  // Returns #1 after the clock edge at which csn was raised at the pad.
  task automatic send_frame(input logic [63:0] f, input int n);
    r_csn = 1'b0;
    tick(c_HALF);
    shift_bits(f, n);
    tick(c_HALF);
    r_csn = 1'b1;
  endtask

  task automatic model_frame(input int n, input bit par_ok, input logic [c_ADDR_W-1:0] a,
                             input logic [c_DATA_W-1:0] d, input bit rdy);
    if (n != c_FL) m_err = 2'd1;
    else if (!par_ok) m_err = 2'd3;
    else if (m_valid && !rdy) m_err = 2'd2;
    else begin
      m_valid = 1'b1;
      m_addr  = a;
      m_data  = d;
      m_err   = 2'd0;
    end
  endtask

  task automatic consume();
    r_ready = 1'b1;
    tick(1);
    r_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic frame_and_check(input string tag, input logic [c_ADDR_W-1:0] a,
                                 input logic [c_DATA_W-1:0] d, input int n);
    send_frame(frame_bits(a, d), n);
    tick(8);
    model_frame(n, 1'b1, a, d, 1'b0);
    check_model(tag);
  endtask

  initial begin
    int offs [7] = '{-2, -1, 0, 0, 0, 1, 2};
    logic [c_ADDR_W-1:0] ra;
    logic [c_DATA_W-1:0] rd;
    int                  rn;

    // Reset state
    r_rst_n = 1'b0;
    tick(4);
    check_reset("reset");
    r_rst_n = 1'b1;
    tick(10);

    // Good frame with latency check
    send_frame(frame_bits(4'h5, 24'hA5A5A5), c_FL);
    tick(4);
    chk("latency4.valid", 32'(w_valid), 32'd0);
    tick(1);
    model_frame(c_FL, 1'b1, 4'h5, 24'hA5A5A5, 1'b0);
    check_model("good");
    r_ready = 1'b1;
    tick(1);
    r_ready = 1'b0;
    m_valid = 1'b0;
    chk("handshake.valid", 32'(w_valid), 32'd0);
    tick(10);

    // Short and long frames
    frame_and_check("short", 4'h3, 24'h123456, c_FL - 1);
    tick(10);
    frame_and_check("long", 4'h3, 24'h123456, c_FL + 1);
    tick(10);

    // Overrun: second word discarded, first one kept
    frame_and_check("ovr1", 4'h1, 24'h000001, c_FL);
    tick(10);
    frame_and_check("ovr2", 4'h1, 24'h000002, c_FL);
    tick(10);

    // Coincident handshake: ready high exactly in the CHECK cycle
    send_frame(frame_bits(4'h2, 24'h000002), c_FL);
    tick(4);
    chk("coinc.busy_in_check", 32'(w_busy), 32'd1);
    r_ready = 1'b1;
    tick(1);
    r_ready = 1'b0;
    model_frame(c_FL, 1'b1, 4'h2, 24'h000002, 1'b1);
    check_model("coinc");
    tick(10);

    // Reset mid-frame, after leaving a framing error flagged
    frame_and_check("pre_rst_short", 4'h7, 24'h777777, c_FL - 2);
    tick(10);
    r_csn = 1'b0;
    tick(c_HALF);
    shift_bits(frame_bits(4'h9, 24'h999999), 10);
    r_rst_n = 1'b0;
    tick(2);
    check_reset("mid_rst");
    m_valid = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_err   = 2'd0;
    r_csn   = 1'b1;
    tick(10);
    r_rst_n = 1'b1;
    tick(10);
    frame_and_check("post_rst", 4'hC, 24'h3C3C3C, c_FL);
    tick(10);

`ifdef GPIO_SERIAL_CFG_PARITY_EN
    consume();
    tick(10);
    send_frame(frame_bits(4'h6, 24'h0F0F01) ^ 64'd1, c_FL);
    tick(8);
    model_frame(c_FL, 1'b0, 4'h6, 24'h0F0F01, 1'b0);
    check_model("par_bad");
    tick(10);
    frame_and_check("par_good", 4'h6, 24'h0F0F01, c_FL);
    tick(10);
`endif

    // Randomized frames: random lengths around nominal, random consumption
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) consume();
      ra = c_ADDR_W'($urandom);
      rd = c_DATA_W'($urandom);
      rn = c_FL + offs[$urandom_range(0, 6)];
      frame_and_check($sformatf("rnd%0d", k), ra, rd, rn);
      tick(10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
